// File: rtl/var_len_packer.sv
// var_len_packer: packs MSB-aligned variable-length byte chunks from LANES input
// lanes into dense OUT_BYTES-wide words. Leftover bytes wait in a residual buffer
// and are carried into the next beat. An inLast beat drains the buffer, ending
// with a short (possibly empty) word flagged outLast.
// Invariant: every residual byte at or beyond 'level' is zero. Shifts and masked
// appends can then be merged with a plain OR, and the final word is already padded.
module var_len_packer #(
   parameter int LANES      = 2,
   parameter int LANE_BYTES = 4,
   parameter int OUT_BYTES  = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wrtEn,
   input  logic                           inLast,
   input  logic [LANES*LANE_BYTES*8-1:0]  dataIn,
   input  logic [LANES*LEN_WIDTH-1:0]     inLen,
   output logic                           inReady,
   output logic                           outValid,
   input  logic                           outReady,
   output logic [OUT_BYTES*8-1:0]         dataOut,
   output logic [LEN_WIDTH-1:0]           outLen,
   output logic                           outLast
);

   localparam int LANE_BITS = LANE_BYTES * 8;
   localparam int BUF_BYTES = 2 * OUT_BYTES - 1;
   localparam int BUF_BITS  = BUF_BYTES * 8;
   localparam int LVL_W     = $clog2(2 * OUT_BYTES);
   localparam logic [LVL_W-1:0] OUT_LVL = LVL_W'(OUT_BYTES);

   typedef enum logic {ST_RUN, ST_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [BUF_BITS-1:0]    res_q, res_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic                   out_valid_q, out_valid_d;
   logic [LEN_WIDTH-1:0]   out_len_q, out_len_d;
   logic                   out_last_q, out_last_d;

   logic                   popped;
   logic                   accept;
   logic [LVL_W-1:0]       base;
   logic [BUF_BITS-1:0]    merged;

   logic [LANES-1:0][LVL_W-1:0]    clen;
   logic [LANES:0][LVL_W-1:0]      pre;
   logic [LANES-1:0][BUF_BITS-1:0] lane_pos;

   assign popped  = out_valid_q && outReady;
   assign inReady = (state_q == ST_RUN) && ((level_q < OUT_LVL) || outReady);
   assign accept  = wrtEn && inReady;
   // Append offset is measured after this cycle's pop. The DRAIN underflow case
   // never accepts, so the wrapped value there is harmless.
   assign base    = popped ? (level_q - OUT_LVL) : level_q;

   assign dataOut  = res_q[BUF_BITS-1 -: OUT_BYTES*8];
   assign outValid = out_valid_q;
   assign outLen   = out_len_q;
   assign outLast  = out_last_q;

   // Per-lane clamp, running byte offset, and masked placement into buffer coordinates.
   assign pre[0] = '0;
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LEN_WIDTH-1:0] len_raw;
      logic [LANE_BITS-1:0] lane_raw;
      logic [LANE_BITS-1:0] lane_mask;
      logic [LANE_BITS-1:0] lane_clean;

      assign len_raw    = inLen[gi*LEN_WIDTH +: LEN_WIDTH];
      assign lane_raw   = dataIn[gi*LANE_BITS +: LANE_BITS];
      assign clen[gi]   = (len_raw > LEN_WIDTH'(LANE_BYTES)) ? LVL_W'(LANE_BYTES)
                                                              : LVL_W'(len_raw);
      assign pre[gi+1]  = pre[gi] + clen[gi];
      // Bytes past the valid length are zeroed so they cannot corrupt the OR merge.
      assign lane_mask  = ~({LANE_BITS{1'b1}} >> {clen[gi], 3'b000});
      assign lane_clean = lane_raw & lane_mask;
      assign lane_pos[gi] = {lane_clean, {(BUF_BITS-LANE_BITS){1'b0}}}
                            >> {base + pre[gi], 3'b000};
   end

   // OR together all placed lanes; they occupy disjoint byte ranges.
   always_comb begin
      merged = '0;
      for (int i = 0; i < LANES; i++) begin
         merged = merged | lane_pos[i];
      end
   end

   // Next residual contents, fill level, state and registered output flags.
   always_comb begin
      res_d       = res_q;
      level_d     = level_q;
      state_d     = state_q;
      out_valid_d = 1'b0;
      out_len_d   = LEN_WIDTH'(OUT_BYTES);
      out_last_d  = 1'b0;

      if (popped) begin
         res_d = res_q << (OUT_BYTES * 8);
      end
      if (accept) begin
         res_d = res_d | merged;
      end

      case (state_q)
         ST_RUN: begin
            level_d = base + (accept ? pre[LANES] : '0);
            if (accept && inLast) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (popped) begin
               if (out_last_q) begin
                  level_d = '0;
                  state_d = ST_RUN;
               end else begin
                  level_d = level_q - OUT_LVL;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Outputs are derived from the next state so they come straight from flops.
      if (state_d == ST_RUN) begin
         out_valid_d = (level_d >= OUT_LVL);
      end else begin
         out_valid_d = 1'b1;
         if (level_d <= OUT_LVL) begin
            out_len_d  = LEN_WIDTH'(level_d);
            out_last_d = 1'b1;
         end
      end
   end

   // State registers; reset discards any held bytes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         res_q       <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_len_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         out_len_q   <= out_len_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_var_len_packer.sv
// Directed bench for var_len_packer with default parameters (2 lanes x 4 bytes, 8-byte words).
module tb_var_len_packer;

   logic        clk;
   logic        reset;
   logic        wrtEn;
   logic        inLast;
   logic [63:0] dataIn;
   logic [15:0] inLen;
   logic        inReady;
   logic        outValid;
   logic        outReady;
   logic [63:0] dataOut;
   logic [7:0]  outLen;
   logic        outLast;

   int checks;
   int failures;

   var_len_packer #(
      .LANES(2), .LANE_BYTES(4), .OUT_BYTES(8), .LEN_WIDTH(8)
   ) dut (
      .clk(clk), .reset(reset), .wrtEn(wrtEn), .inLast(inLast),
      .dataIn(dataIn), .inLen(inLen), .inReady(inReady),
      .outValid(outValid), .outReady(outReady), .dataOut(dataOut),
      .outLen(outLen), .outLast(outLast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [31:0] l0, input logic [7:0] n0,
                             input logic [31:0] l1, input logic [7:0] n1,
                             input logic last);
      dataIn = {l1, l0};
      inLen  = {n1, n0};
      inLast = last;
      wrtEn  = 1'b1;
      $display("beat lane0=%h/%0d lane1=%h/%0d last=%0b", l0, n0, l1, n1, last);
   endtask

   task automatic idle_in;
      wrtEn  = 1'b0;
      inLast = 1'b0;
      dataIn = '0;
      inLen  = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1; outReady = 1'b0; idle_in();
      #3;
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", outValid); end
      checks++; if (dataOut !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", dataOut); end
      checks++; if (outLen !== 8'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", outLen); end
      checks++; if (outLast !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", outLast); end
      checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", inReady); end
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid;
      outReady = 1'b0;
      drive_beat(32'h1122_3344, 8'd4, 32'h5566_7788, 8'd4, 1'b0);
      tick(); idle_in();
      checks++; if (outValid !== 1'b1 || dataOut !== 64'h1122_3344_5566_7788) begin failures++;
         $display("FAIL mid_word got=%b/%h exp=1/1122334455667788", outValid, dataOut); end
      #2 reset = 1'b1;
      #1;
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", outValid); end
      checks++; if (dataOut !== 64'h0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", dataOut); end
      checks++; if (outLen !== 8'd0) begin failures++; $display("FAIL mid_rst_len got=%0d exp=0", outLen); end
      checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL mid_rst_inready got=%b exp=1", inReady); end
      #1 reset = 1'b0;
      tick();
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%b exp=0", outValid); end
   endtask

   task automatic test_pack;
      outReady = 1'b0;
      drive_beat(32'h4567_0000, 8'd2, 32'h89AB_CDEF, 8'd4, 1'b0);
      tick(); idle_in();
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL pack_a_valid got=%b exp=0", outValid); end
      drive_beat(32'h0102_0304, 8'd4, 32'hDEAD_BEEF, 8'd0, 1'b0);
      #1;
      checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL pack_b_inready got=%b exp=1", inReady); end
      tick(); idle_in();
      checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL pack_b_valid got=%b exp=1", outValid); end
      checks++; if (dataOut !== 64'h4567_89AB_CDEF_0102) begin failures++;
         $display("FAIL pack_b_data got=%h exp=456789abcdef0102", dataOut); end
      checks++; if (outLen !== 8'd8 || outLast !== 1'b0) begin failures++;
         $display("FAIL pack_b_len got=%0d/%b exp=8/0", outLen, outLast); end
   endtask

   task automatic test_drain;
      outReady = 1'b1;
      drive_beat(32'hDEAD_BEEF, 8'd0, 32'hCAFE_F00D, 8'd0, 1'b1);
      #1;
      checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL drain_inready got=%b exp=1", inReady); end
      tick(); idle_in(); outReady = 1'b0;
      #1;
      checks++; if (outValid !== 1'b1 || dataOut !== 64'h0304_0000_0000_0000) begin failures++;
         $display("FAIL drain_data got=%b/%h exp=1/0304000000000000", outValid, dataOut); end
      checks++; if (outLen !== 8'd2 || outLast !== 1'b1) begin failures++;
         $display("FAIL drain_len got=%0d/%b exp=2/1", outLen, outLast); end
      checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL drain_busy got=%b exp=0", inReady); end
      outReady = 1'b1;
      tick(); outReady = 1'b0;
      checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin failures++;
         $display("FAIL drain_done got=%b/%b exp=0/1", outValid, inReady); end
   endtask

   task automatic test_drain_long;
      outReady = 1'b0;
      drive_beat(32'hE0E1_E2E3, 8'd4, 32'hE4E5_9999, 8'd2, 1'b0);
      tick();
      drive_beat(32'hF0F1_F2F3, 8'd4, 32'hF4F5_F6F7, 8'd4, 1'b1);
      tick(); idle_in();
      checks++; if (dataOut !== 64'hE0E1_E2E3_E4E5_F0F1 || outLen !== 8'd8 || outLast !== 1'b0) begin failures++;
         $display("FAIL dlong_w0 got=%h/%0d/%b exp=e0e1e2e3e4e5f0f1/8/0", dataOut, outLen, outLast); end
      outReady = 1'b1;
      tick(); outReady = 1'b0;
      checks++; if (outValid !== 1'b1 || dataOut !== 64'hF2F3_F4F5_F6F7_0000 || outLen !== 8'd6 || outLast !== 1'b1) begin
         failures++;
         $display("FAIL dlong_w1 got=%b/%h/%0d/%b exp=1/f2f3f4f5f6f70000/6/1", outValid, dataOut, outLen, outLast); end
      outReady = 1'b1;
      tick(); outReady = 1'b0;
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL dlong_done got=%b exp=0", outValid); end
   endtask

   task automatic test_backpressure;
      outReady = 1'b0;
      drive_beat(32'hA0A1_A2A3, 8'd4, 32'hA4A5_A6A7, 8'd4, 1'b0);
      tick();
      drive_beat(32'hB0B1_B2B3, 8'd4, 32'hB4B5_B6B7, 8'd4, 1'b0);
      #1;
      checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL bp_inready got=%b exp=0", inReady); end
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++; if (outValid !== 1'b1 || dataOut !== 64'hA0A1_A2A3_A4A5_A6A7) begin failures++;
            $display("FAIL bp_hold%0d got=%b/%h exp=1/a0a1a2a3a4a5a6a7", c, outValid, dataOut); end
      end
      outReady = 1'b1;
      #1;
      checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", inReady); end
      tick(); idle_in();
      checks++; if (outValid !== 1'b1 || dataOut !== 64'hB0B1_B2B3_B4B5_B6B7) begin failures++;
         $display("FAIL bp_next got=%b/%h exp=1/b0b1b2b3b4b5b6b7", outValid, dataOut); end
      tick(); outReady = 1'b0;
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", outValid); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] w;
      outReady = 1'b1;
      for (int i = 0; i < 16; i++) begin
         w = {8'(i), 24'h11_2233, 8'(i), 24'h44_5566};
         drive_beat(w[63:32], 8'd4, w[31:0], 8'd4, 1'b0);
         #1;
         checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, inReady); end
         tick();
         checks++; if (outValid !== 1'b1 || dataOut !== w) begin failures++;
            $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", i, outValid, dataOut, w); end
      end
      idle_in();
      tick(); outReady = 1'b0;
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", outValid); end
   endtask

   task automatic test_clamp_empty;
      outReady = 1'b0;
      drive_beat(32'hC0C1_C2C3, 8'd7, 32'hD0D1_D2D3, 8'd7, 1'b0);
      tick(); idle_in();
      checks++; if (outValid !== 1'b1 || dataOut !== 64'hC0C1_C2C3_D0D1_D2D3 || outLen !== 8'd8) begin failures++;
         $display("FAIL clamp_word got=%b/%h/%0d exp=1/c0c1c2c3d0d1d2d3/8", outValid, dataOut, outLen); end
      outReady = 1'b1;
      tick(); outReady = 1'b0;
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL clamp_popped got=%b exp=0", outValid); end
      drive_beat(32'h1234_5678, 8'd0, 32'h9ABC_DEF0, 8'd0, 1'b1);
      tick(); idle_in();
      checks++; if (outValid !== 1'b1 || outLen !== 8'd0 || outLast !== 1'b1 || dataOut !== 64'h0) begin failures++;
         $display("FAIL empty_word got=%b/%0d/%b/%h exp=1/0/1/0", outValid, outLen, outLast, dataOut); end
      outReady = 1'b1;
      tick(); outReady = 1'b0;
      checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin failures++;
         $display("FAIL empty_done got=%b/%b exp=0/1", outValid, inReady); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_reset_mid();
      test_pack();
      test_drain();
      test_drain_long();
      test_backpressure();
      test_back_to_back();
      test_clamp_empty();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
